// File: rtl/mcp3_afp_pkg.sv
// Shared constants and helpers for the AFP datapath buffering blocks.
package mcp3_afp_pkg;

  // Block RAM read latency in clock edges (address to q).
  localparam int unsigned RAM_RD_LAT = 2;

  // Entries in the register FIFO that sits behind the RAM read port.
  localparam int unsigned OBUF_DEPTH = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mcp3_ram_dp_q.sv
// Simple dual-port block RAM with two registered read stages (q_int, then q).
// A read of the address being written in the same cycle returns the new write data.
module mcp3_ram_dp_q #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  i_wren,
  input  logic [DEPTH_LOG2-1:0] i_wrad,
  input  logic [WIDTH-1:0]      i_wrdata,
  input  logic                  i_rden,
  input  logic [DEPTH_LOG2-1:0] i_rdad,
  output logic [WIDTH-1:0]      o_q
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q_int;
  logic [WIDTH-1:0] r_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wren) r_mem[i_wrad] <= i_wrdata;
  end

  // Two-stage read pipeline; idle stage-1 reads as zero, same-address write bypasses.
  always_ff @(posedge clk) begin
    if (i_rden) begin
      r_q_int <= (i_wren && (i_wrad == i_rdad)) ? i_wrdata : r_mem[i_rdad];
    end else begin
      r_q_int <= '0;
    end
    r_q <= r_q_int;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mcp3_ramfifo_q.sv
// First-word-fall-through FIFO on a 2-cycle block RAM with a 3-entry output buffer.
// Reads are prefetched from the RAM into the output buffer under a credit limit so the
// buffer can never overflow.
module mcp3_ramfifo_q
  import mcp3_afp_pkg::*;
#(
  parameter int unsigned WIDTH        = 36,
  parameter int unsigned DEPTH_LOG2   = 7,
  parameter int unsigned AFULL_THRESH = 124
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2+1:0] count,
  output logic                  overflow
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned RCNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 2;
  localparam int unsigned OCNT_W = clog2(OBUF_DEPTH + 1);
  localparam int unsigned SUM_W  = OCNT_W + 1;

  localparam logic [RCNT_W-1:0]     RAM_FULL = RCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      AFULL    = CNT_W'(AFULL_THRESH);
  localparam logic [SUM_W-1:0]      CREDITS  = SUM_W'(OBUF_DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [RCNT_W-1:0]     r_ram_cnt;
  logic [RAM_RD_LAT-1:0] r_vld;
  logic [OCNT_W-1:0]     r_obuf_cnt;
  logic [WIDTH-1:0]      r_obuf [OBUF_DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic                  w_wr_en;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [SUM_W-1:0]      w_inflight;
  logic [SUM_W-1:0]      w_inflight_d;
  logic [SUM_W-1:0]      w_used;
  logic [RCNT_W-1:0]     w_ram_cnt_d;
  logic [RAM_RD_LAT-1:0] w_vld_d;
  logic [OCNT_W-1:0]     w_obuf_cnt_d;
  logic [OCNT_W-1:0]     w_obuf_wr_idx;
  logic [CNT_W-1:0]      w_count_d;
  logic [WIDTH-1:0]      w_ram_q;
  logic                  w_run;

  // Handshakes, prefetch credit and next-state occupancy.
  always_comb begin
    w_run    = reset_n & ~flush;
    w_wr_en  = wr_valid & ~wr_full;
    w_pop    = rd_valid & rd_ready;
    w_push   = r_vld[RAM_RD_LAT-1];

    w_inflight = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) w_inflight = w_inflight + SUM_W'(r_vld[i]);

    // A word popped this cycle frees its slot at the same edge, which keeps the
    // pipeline streaming one word per clock.
    w_used  = w_inflight + SUM_W'(r_obuf_cnt) - SUM_W'(w_pop);
    w_issue = (r_ram_cnt != '0) && (w_used < CREDITS);

    w_ram_cnt_d  = r_ram_cnt + RCNT_W'(w_wr_en) - RCNT_W'(w_issue);
    w_vld_d      = {r_vld[RAM_RD_LAT-2:0], w_issue};
    w_obuf_cnt_d = r_obuf_cnt + OCNT_W'(w_push) - OCNT_W'(w_pop);

    w_inflight_d = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) w_inflight_d = w_inflight_d + SUM_W'(w_vld_d[i]);

    w_count_d     = CNT_W'(w_ram_cnt_d) + CNT_W'(w_inflight_d) + CNT_W'(w_obuf_cnt_d);
    w_obuf_wr_idx = r_obuf_cnt - OCNT_W'(w_pop);
  end

  mcp3_ram_dp_q #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk      (clk),
    .i_wren   (w_wr_en & w_run),
    .i_wrad   (r_wr_ptr),
    .i_wrdata (wr_data),
    .i_rden   (w_issue & w_run),
    .i_rdad   (r_rd_ptr),
    .o_q      (w_ram_q)
  );

  // Pointers, counters, in-flight tracking and sticky overflow; reset and flush clear all.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_vld      <= '0;
      r_obuf_cnt <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_ram_cnt  <= w_ram_cnt_d;
      r_vld      <= w_vld_d;
      r_obuf_cnt <= w_obuf_cnt_d;
      r_count    <= w_count_d;
      if (wr_valid && wr_full) r_overflow <= 1'b1;
    end
  end

  // Output buffer storage: shift toward the head on pop, land RAM data behind the tail.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int i = 0; i < OBUF_DEPTH - 1; i++) r_obuf[i] <= r_obuf[i+1];
    end
    if (w_push) r_obuf[w_obuf_wr_idx] <= w_ram_q;
  end

  assign wr_full        = (r_ram_cnt == RAM_FULL);
  assign wr_almost_full = (r_count >= AFULL);
  assign rd_valid       = (r_obuf_cnt != '0);
  assign rd_data        = rd_valid ? r_obuf[0] : '0;
  assign count          = r_count;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_mcp3_ramfifo_q.sv
// Self-checking bench for mcp3_ramfifo_q plus a direct bypass check on mcp3_ram_dp_q.
module tb_mcp3_ramfifo_q;

  localparam int unsigned W      = 36;
  localparam int unsigned DL2    = 7;
  localparam int unsigned AFULL  = 124;
  localparam int unsigned CAP    = 131;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_full;
  logic          wr_almost_full;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_ready;
  logic [DL2+1:0] count;
  logic          overflow;

  logic          ram_wren;
  logic [1:0]    ram_wrad;
  logic [7:0]    ram_wrdata;
  logic          ram_rden;
  logic [1:0]    ram_rdad;
  logic [7:0]    ram_q;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mcp3_ramfifo_q #(
    .WIDTH        (W),
    .DEPTH_LOG2   (DL2),
    .AFULL_THRESH (AFULL)
  ) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .count          (count),
    .overflow       (overflow)
  );

  mcp3_ram_dp_q #(
    .WIDTH      (8),
    .DEPTH_LOG2 (2)
  ) u_ram (
    .clk      (clk),
    .i_wren   (ram_wren),
    .i_wrad   (ram_wrad),
    .i_wrdata (ram_wrdata),
    .i_rden   (ram_rden),
    .i_rdad   (ram_rdad),
    .o_q      (ram_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: called at a negedge, drives inputs, scoreboards, checks after the edge.
  task automatic step(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
    logic [W-1:0] held;
    logic [W-1:0] expd;
    bit           hold;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    hold = rd_valid && !rr && !fl;
    held = rd_data;
    if (rd_valid && rr) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        expd = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(expd));
      end
    end else if (!rd_valid) begin
      chk("rd_data_idle", 64'(rd_data), 64'd0);
    end
    if (wv && !wr_full) exp_q.push_back(wd);
    if (fl) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("almost_full", 64'(wr_almost_full), 64'(exp_q.size() >= AFULL));
    if (exp_q.size() < 128) chk("wr_full_early", 64'(wr_full), 64'd0);
    if (hold) begin
      chk("hold_valid", 64'(rd_valid), 64'd1);
      chk("hold_data", 64'(rd_data), 64'(held));
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    bit           wv;
    logic [W-1:0] wd;
    bit           rr;
    int           exp_count;
    bit           exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int accepted;
    int cyc;
    bit acc;
    logic [W-1:0] d;

    reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    ram_wren = 1'b0; ram_wrad = '0; ram_wrdata = '0; ram_rden = 1'b0; ram_rdad = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(wr_full), 64'd0);
    chk("rst_afull", 64'(wr_almost_full), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Single-word latency: accepted at edge N, visible after edge N+3.
    vecs[0] = '{1'b1, 36'h0_DEAD_BEEF, 1'b1, 1, 1'b0, '0};
    vecs[1] = '{1'b0, '0, 1'b1, 1, 1'b0, '0};
    vecs[2] = '{1'b0, '0, 1'b1, 1, 1'b0, '0};
    vecs[3] = '{1'b0, '0, 1'b1, 1, 1'b1, 36'h0_DEAD_BEEF};
    vecs[4] = '{1'b0, '0, 1'b1, 0, 1'b0, '0};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr, 1'b0);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].exp_data));
    end

    // Fill to total capacity with the consumer stalled.
    for (int i = 0; i < CAP; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("fill_full", 64'(wr_full), 64'd1);
    chk("fill_count", 64'(count), 64'(CAP));
    chk("fill_afull", 64'(wr_almost_full), 64'd1);
    chk("fill_ovf", 64'(overflow), 64'd0);
    step(1'b1, 36'h9_9999_9999, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'(CAP));
    drain(400);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("drained_full", 64'(wr_full), 64'd0);

    // Streaming with a randomly stalling consumer.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      acc = !wr_full;
      d = W'(accepted) ^ 36'h5_A5A5_0000;
      step(acc, d, 1'($urandom_range(0, 1)), 1'b0);
      if (acc) accepted++;
      cyc++;
    end
    if (accepted < 1000) chk("stream_timeout", 64'(accepted), 64'd1000);
    drain(2000);

    // Flush with two reads in flight.
    step(1'b1, 36'h1_1111_1111, 1'b0, 1'b0);
    step(1'b1, 36'h2_2222_2222, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("flush_valid", 64'(rd_valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_count", 64'(count), 64'd0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 36'h7_0000_0000 + W'(i), 1'b0, 1'b0);
    drain(50);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // RAM same-address write/read bypass and plain readback.
    ram_wren = 1'b1; ram_wrad = 2'd3; ram_wrdata = 8'h11; ram_rden = 1'b0;
    @(posedge clk); @(negedge clk);
    ram_wrdata = 8'hA5; ram_rden = 1'b1; ram_rdad = 2'd3;
    @(posedge clk); @(negedge clk);
    ram_wren = 1'b0; ram_rden = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ram_bypass", 64'(ram_q), 64'hA5);
    ram_rden = 1'b1;
    @(posedge clk); @(negedge clk);
    ram_rden = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ram_read", 64'(ram_q), 64'hA5);
    @(posedge clk); @(negedge clk);
    chk("ram_idle", 64'(ram_q), 64'h0);

    // Fill, overflow, then reset with flush also high.
    cyc = 0;
    while (!wr_full && cyc < 300) begin
      step(1'b1, W'(cyc) + 36'h3_0000_0000, 1'b0, 1'b0);
      cyc++;
    end
    chk("refill_full", 64'(wr_full), 64'd1);
    step(1'b1, '0, 1'b0, 1'b0);
    chk("refill_ovf", 64'(overflow), 64'd1);
    reset_n = 1'b0; flush = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q.delete();
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_full", 64'(wr_full), 64'd0);
    chk("rst2_afull", 64'(wr_almost_full), 64'd0);
    chk("rst2_valid", 64'(rd_valid), 64'd0);
    chk("rst2_data", 64'(rd_data), 64'd0);
    chk("rst2_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    chk("rst2_quiet", 64'(rd_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
